// File: rtl/binarize_scanner_if.sv
// Handshake bundle between the scanner, its two ROM readers and the downstream frame writer.
interface binarize_scanner_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              iStart;
  logic              oBusy;
  logic              oDone;
  logic [ADDR_W-1:0] oRomCol;
  logic [ADDR_W-1:0] oRomRow;
  logic [DATA_W-1:0] iPixel;
  logic [DATA_W-1:0] iThresh;
  logic              oValid;
  logic              iReady;
  logic              oBin;
  logic [ADDR_W-1:0] oCol;
  logic [ADDR_W-1:0] oRow;
  logic              oLast;

  modport slave (
    input  iStart, iPixel, iThresh, iReady,
    output oBusy, oDone, oRomCol, oRomRow, oValid, oBin, oCol, oRow, oLast
  );

  modport master (
    output iStart, iPixel, iThresh, iReady,
    input  oBusy, oDone, oRomCol, oRomRow, oValid, oBin, oCol, oRow, oLast
  );
endinterface

// File: rtl/binarize_scanner.sv
// Raster-scans a 2^ADDR_W square image, thresholds each pixel against its ROM threshold and
// streams 1-bit results with coordinates; 2-cycle start latency, full stall on !iReady.
module binarize_scanner #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  binarize_scanner_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_col_q, cnt_col_d, cnt_row_q, cnt_row_d;
  logic [ADDR_W-1:0] s1_col_q, s1_col_d, s1_row_q, s1_row_d;
  logic              s1_vld_q, s1_vld_d;
  logic              out_vld_q, out_vld_d, out_bin_q, out_bin_d, out_last_q, out_last_d;
  logic [ADDR_W-1:0] out_col_q, out_col_d, out_row_q, out_row_d;
  logic              done_q, done_d;

  logic en, issue, cnt_max, s1_max, gt, bin;

  assign en      = !out_vld_q || bus.iReady;
  assign issue   = (state_q == SCAN);
  assign cnt_max = (&cnt_col_q) && (&cnt_row_q);
  assign s1_max  = (&s1_col_q) && (&s1_row_q);
  assign gt      = (bus.iPixel > bus.iThresh);
  assign bin     = INVERT ? !gt : gt;

  // While stalled the ROMs re-read the stage-1 address so their data stays aligned with its tag.
  assign bus.oRomCol = en ? cnt_col_q : s1_col_q;
  assign bus.oRomRow = en ? cnt_row_q : s1_row_q;

  assign bus.oBusy  = (state_q != IDLE);
  assign bus.oDone  = done_q;
  assign bus.oValid = out_vld_q;
  assign bus.oBin   = out_bin_q;
  assign bus.oCol   = out_col_q;
  assign bus.oRow   = out_row_q;
  assign bus.oLast  = out_last_q;

  always_comb begin
    state_d    = state_q;
    cnt_col_d  = cnt_col_q;
    cnt_row_d  = cnt_row_q;
    s1_col_d   = s1_col_q;
    s1_row_d   = s1_row_q;
    s1_vld_d   = s1_vld_q;
    out_vld_d  = out_vld_q;
    out_bin_d  = out_bin_q;
    out_col_d  = out_col_q;
    out_row_d  = out_row_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;

    if (en) begin
      out_bin_d  = bin;
      out_col_d  = s1_col_q;
      out_row_d  = s1_row_q;
      out_vld_d  = s1_vld_q;
      out_last_d = s1_vld_q && s1_max;
      s1_col_d   = cnt_col_q;
      s1_row_d   = cnt_row_q;
      s1_vld_d   = issue;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          state_d   = SCAN;
          cnt_col_d = '0;
          cnt_row_d = '0;
        end
      end
      SCAN: begin
        if (en) begin
          cnt_col_d = cnt_col_q + 1'b1;
          if (&cnt_col_q) cnt_row_d = cnt_row_q + 1'b1;
          if (cnt_max) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_vld_q && bus.iReady && out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_col_q  <= '0;
      cnt_row_q  <= '0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s1_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_bin_q  <= 1'b0;
      out_col_q  <= '0;
      out_row_q  <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_col_q  <= cnt_col_d;
      cnt_row_q  <= cnt_row_d;
      s1_col_q   <= s1_col_d;
      s1_row_q   <= s1_row_d;
      s1_vld_q   <= s1_vld_d;
      out_vld_q  <= out_vld_d;
      out_bin_q  <= out_bin_d;
      out_col_q  <= out_col_d;
      out_row_q  <= out_row_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_binarize_scanner.sv
// Bench for binarize_scanner: expected pixels are queued when a frame is started and a
// negedge monitor pops them on every output handshake; a second INVERT=1 instance covers ties.
module tb_binarize_scanner;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  binarize_scanner_if #(.ADDR_W(7), .DATA_W(8)) bif ();
  binarize_scanner_if #(.ADDR_W(7), .DATA_W(8)) iif ();

  binarize_scanner #(.ADDR_W(7), .DATA_W(8), .INVERT(1'b0)) dut (
    .clock(clock), .reset(reset), .bus(bif.slave));
  binarize_scanner #(.ADDR_W(7), .DATA_W(8), .INVERT(1'b1)) dut_inv (
    .clock(clock), .reset(reset), .bus(iif.slave));

  typedef struct packed {
    logic [6:0] col;
    logic [6:0] row;
    logic       bin;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   inv_idx = 0;
  int   inv_done = 0;
  bit   mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM models: mode 0 gives pixel=col+row vs 128, mode 1 gives pixel==thresh everywhere.
  always @(posedge clock) begin
    bif.iPixel  <= mode ? {bif.oRomCol[3:0], bif.oRomRow[3:0]} : ({1'b0, bif.oRomCol} + {1'b0, bif.oRomRow});
    bif.iThresh <= mode ? {bif.oRomCol[3:0], bif.oRomRow[3:0]} : 8'd128;
    iif.iPixel  <= {iif.oRomRow[3:0], iif.oRomCol[3:0]};
    iif.iThresh <= {iif.oRomRow[3:0], iif.oRomCol[3:0]};
  end

  exp_t held;
  bit   held_vld = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (bif.oDone) done_cnt++;
      if (held_vld) begin
        check("held_stable", {bif.oValid, bif.oCol, bif.oRow, bif.oBin, bif.oLast},
              {1'b1, held.col, held.row, held.bin, held.last});
      end
      if (bif.oValid && bif.iReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {bif.oCol, bif.oRow}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {bif.oCol, bif.oRow, bif.oBin, bif.oLast}, {e.col, e.row, e.bin, e.last});
        end
      end
      held_vld = bif.oValid && !bif.iReady;
      held     = '{col: bif.oCol, row: bif.oRow, bin: bif.oBin, last: bif.oLast};

      if (iif.oDone) inv_done++;
      if (iif.oValid && iif.iReady) begin
        check("inv_coord", {iif.oCol, iif.oRow}, {inv_idx[6:0], inv_idx[13:7]});
        check("inv_bin_tie", iif.oBin, 1'b1);
        check("inv_last", iif.oLast, (inv_idx == 16383));
        inv_idx++;
      end
    end else begin
      held_vld = 1'b0;
    end
  end

  task automatic push_frame(input bit m);
    exp_t e;
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        e.col  = c[6:0];
        e.row  = r[6:0];
        e.bin  = m ? 1'b0 : ((c + r) > 128);
        e.last = (c == 127) && (r == 127);
        exp_q.push_back(e);
      end
    end
  endtask

  // Pulses iStart for one sampling edge and checks the two-cycle start latency.
  task automatic start_frame(input bit with_inv);
    @(posedge clock); #1;
    bif.iStart = 1'b1;
    iif.iStart = with_inv;
    @(posedge clock); #1;
    bif.iStart = 1'b0;
    iif.iStart = 1'b0;
    @(negedge clock);
    check("start_busy", bif.oBusy, 1'b1);
    check("latency_k1", bif.oValid, 1'b0);
    @(negedge clock);
    check("latency_k2_pre", bif.oValid, 1'b0);
    @(negedge clock);
    check("latency_first", {bif.oValid, bif.oCol, bif.oRow}, {1'b1, 7'd0, 7'd0});
  endtask

  // Returns #1 after the edge that raised oDone, so the caller can act inside that cycle.
  task automatic run_until_done(input int bound, input bit rnd, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clock); #1;
      if (rnd) bif.iReady = ($urandom_range(0, 1) == 1);
      if (bif.oDone) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit hit;
    bit found;
    int d0;
    reset = 1'b1;
    bif.iStart = 1'b0;
    bif.iReady = 1'b1;
    iif.iStart = 1'b0;
    iif.iReady = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_outputs", {bif.oBusy, bif.oDone, bif.oValid, bif.oBin, bif.oLast},  5'b0);
    check("rst_coords", {bif.oCol, bif.oRow}, 14'd0);
    check("rst_rom_addr", {bif.oRomCol, bif.oRomRow}, 14'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Frame A: col+row > 128, with a 20-cycle stall at (5,3) and a stray mid-scan iStart.
    push_frame(1'b0);
    start_frame(1'b0);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clock); #1;
      if (bif.oValid && bif.oCol == 7'd5 && bif.oRow == 7'd3) found = 1'b1;
    end
    check("stall_found", found, 1'b1);
    bif.iReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("stall_hold", {bif.oValid, bif.oCol, bif.oRow}, {1'b1, 7'd5, 7'd3});
    end
    @(posedge clock); #1;
    bif.iReady = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("after_stall", {bif.oValid, bif.oCol, bif.oRow}, {1'b1, 7'd6, 7'd3});
    @(posedge clock); #1;
    bif.iStart = 1'b1;
    @(posedge clock); #1;
    bif.iStart = 1'b0;
    run_until_done(20000, 1'b0, hit);

    // Frame B starts in the oDone cycle and runs with random backpressure.
    bif.iStart = 1'b1;
    push_frame(1'b0);
    @(posedge clock); #1;
    bif.iStart = 1'b0;
    @(negedge clock);
    check("doneA_count", done_cnt, 1);
    check("restart_busy", bif.oBusy, 1'b1);
    run_until_done(60000, 1'b1, hit);
    bif.iReady = 1'b1;
    repeat (3) @(negedge clock);
    check("doneB_count", done_cnt, 2);
    check("frameB_drained", exp_q.size(), 0);
    check("idle_after_B", bif.oBusy, 1'b0);

    // Frame C is cut short by reset.
    push_frame(1'b0);
    start_frame(1'b0);
    repeat (4000) @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_valid", bif.oValid, 1'b0);
    check("midrst_busy", bif.oBusy, 1'b0);
    d0 = done_cnt;
    repeat (10) @(negedge clock);
    check("midrst_no_done", done_cnt, d0);

    // Frame D: pixel == threshold on both instances.
    mode = 1'b1;
    push_frame(1'b1);
    start_frame(1'b1);
    run_until_done(20000, 1'b0, hit);
    repeat (3) @(negedge clock);
    check("doneD_count", done_cnt, d0 + 1);
    check("frameD_drained", exp_q.size(), 0);
    check("inv_count", inv_idx, 16384);
    check("inv_done", inv_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
